// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
// MEM-stage load/store unit: decodes the EX/MEM register, runs a req/gnt/rvalid
// data-memory access, formats load data for MEM/WB and stalls until done.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_q,
  input  logic [XLEN-1:0] rd2q,
  input  logic [XLEN-1:0] instq1,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic            stall,
  output logic            mem_fault
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [XLEN-1:0] load_data_q, load_data_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [1:0]      a;
  logic            is_load, is_store, memop;
  logic            illegal_f3, misaligned, fault_raw, memop_ok;
  logic [3:0]      be_st;
  logic [XLEN-1:0] wdata_st;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_fmt;
  logic            unused_inst;

  assign unused_inst = ^{instq1[31:15], instq1[11:7]};

  // Decode and fault detection
  always_comb begin
    opcode   = instq1[6:0];
    funct3   = instq1[14:12];
    a        = alu_q[1:0];
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    memop    = is_load || is_store;

    illegal_f3 = 1'b0;
    if (is_load) begin
      illegal_f3 = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                     funct3 == 3'b100 || funct3 == 3'b101);
    end else if (is_store) begin
      illegal_f3 = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    end

    misaligned = ((funct3[1:0] == 2'b01) && a[0]) ||
                 ((funct3[1:0] == 2'b10) && (a != 2'b00));
    fault_raw  = memop && (misaligned || illegal_f3);
    memop_ok   = memop && !fault_raw;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    be_st    = 4'b0000;
    wdata_st = '0;
    case (funct3[1:0])
      2'b00: begin
        be_st    = 4'b0001 << a;
        wdata_st = {4{rd2q[7:0]}};
      end
      2'b01: begin
        be_st    = 4'b0011 << a;
        wdata_st = {2{rd2q[15:0]}};
      end
      2'b10: begin
        be_st    = 4'b1111;
        wdata_st = rd2q;
      end
      default: begin
        be_st    = 4'b0000;
        wdata_st = '0;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    lane     = dmem_rdata >> {a, 3'b000};
    load_fmt = dmem_rdata;
    case (funct3)
      3'b000:  load_fmt = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  // State register and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (memop_ok) begin
          if (dmem_gnt) state_d = is_store ? S_DONE : S_WAIT;
          else          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_gnt) state_d = is_store ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          load_data_d = load_fmt;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; reset forces the memory port and pipeline controls quiet
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    stall      = 1'b0;
    mem_fault  = 1'b0;
    dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
    if (!rst) begin
      mem_fault = fault_raw;
      stall     = memop_ok && (state_q != S_DONE);
      case (state_q)
        S_IDLE:  dmem_req = memop_ok;
        S_REQ:   dmem_req = 1'b1;
        default: dmem_req = 1'b0;
      endcase
      if (memop_ok && is_store) begin
        dmem_we    = 1'b1;
        dmem_be    = be_st;
        dmem_wdata = wdata_st;
      end
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
// Randomized bench for mem_stage_lsu: a transaction-level model predicts port
// values, stall duration and load results for each EX/MEM instruction.
module tb_mem_stage_lsu;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_q, rd2q, instq1;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_be;
  logic        stall, mem_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] ld_exp;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .alu_q(alu_q), .rd2q(rd2q), .instq1(instq1),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .load_data(load_data),
    .stall(stall), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    logic [16:0] hi;
    hi = 17'($urandom);
    return {hi, f3, 5'd3, opc};
  endfunction

  // One instruction held in EX/MEM from its first MEM cycle until the pipeline advances.
  task automatic do_op(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int gdly, input int rdly);
    logic [2:0]  f3;
    logic [1:0]  a;
    logic        ld, st, legal, fault;
    int unsigned sz, nb;
    logic [31:0] exp_wd, exp_ld, field, mask;
    logic [3:0]  exp_be;

    f3 = inst[14:12];
    a  = addr[1:0];
    ld = (inst[6:0] == OPC_LOAD);
    st = (inst[6:0] == OPC_STORE);
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    sz = 1 << f3[1:0];
    fault = (ld || st) && (!legal || ((addr % sz) != 0));

    exp_be = 4'b0000;
    exp_wd = 32'h0;
    if (st && !fault) begin
      exp_be = 4'(((1 << sz) - 1) << a);
      if (sz == 1)      exp_wd = 32'(wd[7:0]) * 32'h01010101;
      else if (sz == 2) exp_wd = 32'(wd[15:0]) * 32'h00010001;
      else              exp_wd = wd;
    end

    exp_ld = rdat;
    if (sz < 4) begin
      nb    = 8 * sz;
      mask  = (32'd1 << nb) - 32'd1;
      field = (rdat >> (8 * a)) & mask;
      if (!f3[2] && field[nb-1]) exp_ld = field - (32'd1 << nb);
      else                       exp_ld = field;
    end

    instq1 = inst; alu_q = addr; rd2q = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;

    if (!(ld || st) || fault) begin
      #1;
      chk("fault", 32'(mem_fault), 32'(fault));
      chk("nomem_req", 32'(dmem_req), 32'h0);
      chk("nomem_stall", 32'(stall), 32'h0);
      chk("nomem_hold", load_data, ld_exp);
      @(negedge clk);
      return;
    end

    for (int k = 0; k <= gdly; k++) begin
      dmem_gnt    = (k == gdly);
      dmem_rvalid = (k != gdly) && ($urandom_range(0, 3) == 0);
      dmem_rdata  = $urandom;
      #1;
      chk("req", 32'(dmem_req), 32'h1);
      chk("req_stall", 32'(stall), 32'h1);
      chk("we", 32'(dmem_we), 32'(st));
      chk("addr", dmem_addr, {addr[31:2], 2'b00});
      chk("be", 32'(dmem_be), 32'(exp_be));
      chk("wdata", dmem_wdata, exp_wd);
      chk("req_fault", 32'(mem_fault), 32'h0);
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;

    if (ld) begin
      for (int k = 0; k <= rdly; k++) begin
        dmem_rvalid = (k == rdly);
        dmem_rdata  = dmem_rvalid ? rdat : $urandom;
        #1;
        chk("wait_req", 32'(dmem_req), 32'h0);
        chk("wait_stall", 32'(stall), 32'h1);
        @(negedge clk);
      end
      dmem_rvalid = 1'b0;
      ld_exp = exp_ld;
    end

    #1;
    chk("done_stall", 32'(stall), 32'h0);
    chk("done_req", 32'(dmem_req), 32'h0);
    chk("load_data", load_data, ld_exp);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] inst, addr;
    logic [2:0]  f3;
    int          r;

    rst = 1'b1;
    instq1 = mk_inst(OPC_LOAD, 3'b010);
    alu_q = 32'h0000_3000; rd2q = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    ld_exp = 32'h0;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_req", 32'(dmem_req), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_ld", load_data, 32'h0);
      chk("rst_we_be", {27'h0, dmem_we, dmem_be}, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;

    do_op(mk_inst(OPC_LOAD, 3'b010), 32'h0000_3000, 32'h0, 32'h1234_5678, 0, 0);
    chk("lw_const", load_data, 32'h1234_5678);

    do_op(mk_inst(OPC_STORE, 3'b000), 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 0);
    do_op(mk_inst(OPC_LOAD, 3'b000), 32'h0000_2002, 32'h0, 32'h0080_FF00, 3, 0);
    chk("lb_const", load_data, 32'hFFFF_FF80);
    do_op(mk_inst(OPC_LOAD, 3'b100), 32'h0000_2002, 32'h0, 32'h0080_FF00, 3, 0);
    chk("lbu_const", load_data, 32'h0000_0080);
    do_op(mk_inst(OPC_LOAD, 3'b001), 32'h0000_2001, 32'h0, 32'h0, 0, 0);
    do_op(mk_inst(OPC_LOAD, 3'b011), 32'h0000_2000, 32'h0, 32'h0, 0, 0);

    // Reset during WAIT, then a stale rvalid after release
    instq1 = mk_inst(OPC_LOAD, 3'b010); alu_q = 32'h0000_4000;
    dmem_gnt = 1'b1;
    #1 chk("rw_req", 32'(dmem_req), 32'h1);
    @(negedge clk);
    dmem_gnt = 1'b0; rst = 1'b1;
    #1;
    chk("rw_rst_req", 32'(dmem_req), 32'h0);
    chk("rw_rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b0; instq1 = 32'h0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rw_idle_stall", 32'(stall), 32'h0);
    chk("rw_idle_req", 32'(dmem_req), 32'h0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    ld_exp = 32'h0;
    #1 chk("rw_ld", load_data, 32'h0);
    @(negedge clk);

    do_op(mk_inst(OPC_STORE, 3'b010), 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 0, 0);
    do_op(mk_inst(OPC_LOAD, 3'b101), 32'h0000_5002, 32'h0, 32'h8001_0000, 0, 0);
    chk("lhu_const", load_data, 32'h0000_8001);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
          inst = mk_inst(OPC_LOAD, f3);
        end
        5, 6, 7: begin
          f3 = 3'($urandom_range(0, 2));
          inst = mk_inst(OPC_STORE, f3);
        end
        8: begin
          if ($urandom_range(0, 1) == 1) inst = mk_inst(OPC_STORE, 3'($urandom_range(3, 7)));
          else begin
            case ($urandom_range(0, 2))
              0: f3 = 3'd3;
              1: f3 = 3'd6;
              default: f3 = 3'd7;
            endcase
            inst = mk_inst(OPC_LOAD, f3);
          end
        end
        default: inst = ($urandom_range(0, 1) == 1) ? 32'h0 : mk_inst(OPC_ALU, 3'($urandom));
      endcase
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (inst[13:12] == 2'b01) addr[0] = 1'b0;
        else if (inst[13:12] == 2'b10) addr[1:0] = 2'b00;
      end
      do_op(inst, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
